uart_receiver: RTL and testbench

Serial-to-parallel 8N1 UART receiver for the system clock domain. It turns the asynchronous `uart_rx` pin into bytes, presented on a one-entry valid/ready output register. It is the receive end of the link whose transmit end drives `TxD`, and it sits inside `CoreWrapper` between the `uart_rx` pin and the core's MMIO/UART consumer.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_receiver.sv | 169 ++++++++++++++++
 tb/tb_uart_receiver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and the matching transmitter.
//   DATA_W        : character width in bits (8)
//   uart_state_e  : frame FSM states
//   clks_per_bit  : system clocks per bit cell (integer division, freq / baud)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for a single asynchronous bit.
//   RST_VAL : value both flops take during reset
// Ports:
//   clk    in  destination clock
//   nReset in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronized output (2 cycles latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nReset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
// defined) with a one-entry valid/ready output register.
// Parameters:
//   CLK_FREQ_HZ : clk frequency
//   BAUD        : line rate; CLK_FREQ_HZ / BAUD must be >= 4
// Ports:
//   clk        in  system clock
//   nReset     in  asynchronous active-low reset
//   rxd        in  raw serial line, idles high, asynchronous to clk
//   data       out received byte
//   valid      out data holds an unconsumed byte
//   ready      in  consumer takes data when valid && ready
//   frame_err  out one-cycle pulse, stop bit sampled low
//   overrun    out one-cycle pulse, completed byte dropped (register full)
//   parity_err out one-cycle pulse, even-parity mismatch (0 without macro)
// Build option: `define UART_RX_PARITY_EN for 8E1 framing.
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int HALF  = CPB / 2;
  localparam int TMR_W = $clog2(CPB);
  // Timer counts down to zero, so a reload of N-1 lands the sample N cycles later.
  localparam logic [TMR_W-1:0] TMR_BIT  = TMR_W'(CPB - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(HALF - 1);

  logic              rx_s;
  logic              rx_q;
  uart_state_e       state;
  logic [TMR_W-1:0]  timer;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              sample;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .nReset (nReset),
    .d      (rxd),
    .q      (rx_s)
  );

  assign sample = (timer == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_err_q;
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      rx_q      <= 1'b1;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_q      <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      // A load in ST_STOP below overrides this clear.
      if (valid && ready) valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Edge-triggered, so a held-low line (break) cannot retrigger.
          if (rx_q && !rx_s) begin
            timer <= TMR_HALF;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (sample) begin
            timer   <= TMR_BIT;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ST_DATA: begin
          if (sample) begin
            timer   <= TMR_BIT;
            shift   <= {rx_s, shift[DATA_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (sample) begin
            timer   <= TMR_BIT;
            // Even parity: data bits plus parity bit must XOR to zero.
            par_bad <= ^{shift, rx_s};
            state   <= ST_STOP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (sample) begin
            state <= ST_IDLE;
            if (rx_s) begin
              if (!valid || ready) begin
                data  <= shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_bad;
`endif
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver at 1 MHz / 100 kBd (10 clocks per bit).
// Build with +define+UART_RX_PARITY_EN to exercise the 8E1 variant.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Two synchronizer cycles, then the stop sample HALF + (NBITS-1) bit cells
  // after the detected edge, then one register cycle.
  localparam int LAT = 2 + HALF + (NBITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_receiver #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor: counts flag cycles, logs handed-over bytes.
  int         cyc = 0;
  int         vld_cycles, fe_cycles, ov_cycles, pe_cycles;
  int         first_vld, pe_cyc, drive_cyc;
  logic       vld_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nReset) begin
      if (valid && !vld_prev && first_vld < 0) first_vld = cyc;
      if (valid) vld_cycles++;
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cycles++;
      if (overrun) ov_cycles++;
      if (parity_err) begin
        pe_cycles++;
        pe_cyc = cyc;
      end
    end
    vld_prev = valid;
  end

  task automatic clear_mon();
    vld_cycles = 0; fe_cycles = 0; ov_cycles = 0; pe_cycles = 0;
    first_vld = -1; pe_cyc = -1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame; the line is left at the stop-bit level.
  task automatic send(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    rxd = 1'b0;
    drive_cyc = cyc;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    repeat (CPB) tick();
`else
    if (par_flip) rxd = 1'b1;
`endif
    rxd = stop_bit;
    repeat (CPB) tick();
  endtask

  task automatic check_queue(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    clear_mon();
    repeat (3) tick();
    check("rst_data", data, 8'h00);
    check("rst_flags", {valid, frame_err, overrun, parity_err}, 4'b0000);
    nReset = 1'b1;
    idle(2 * CPB);

    // Single frame, ready high: one-cycle valid with fixed latency.
    ready = 1'b1;
    clear_mon();
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0);
    idle(2 * CPB);
    check_queue("a5");
    check("a5_valid_width", vld_cycles, 1);
    check("a5_latency", first_vld - drive_cyc, LAT);
    check("a5_flags", fe_cycles + ov_cycles + pe_cycles, 0);

    // Random bytes with random gaps, including zero gap.
    clear_mon();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, 1'b1, 1'b0);
      idle($urandom_range(0, 15));
    end
    idle(2 * CPB);
    check_queue("rand");
    check("rand_flags", fe_cycles + ov_cycles + pe_cycles, 0);

    // Back-to-back with ready low: second byte overruns.
    ready = 1'b0;
    clear_mon();
    send(8'h3C, 1'b1, 1'b0);
    send(8'hC3, 1'b1, 1'b0);
    idle(2 * CPB);
    check("ovr_data", data, 8'h3C);
    check("ovr_valid", valid, 1'b1);
    check("ovr_pulses", ov_cycles, 1);
    check("ovr_fe", fe_cycles, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("ovr_drained_valid", valid, 1'b0);
    exp_q.push_back(8'h3C);
    check_queue("ovr");
    ready = 1'b1;

    // Short glitch must not start a frame; next frame still good.
    clear_mon();
    rxd = 1'b0;
    repeat (3) tick();
    idle(3 * CPB);
    check("glitch_valid", vld_cycles, 0);
    check("glitch_flags", fe_cycles + ov_cycles + pe_cycles, 0);
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, 1'b0);
    idle(2 * CPB);
    check_queue("glitch_55");

    // Framing error, then line held low (break) before release.
    clear_mon();
    send(8'hFF, 1'b0, 1'b0);
    repeat (30 - CPB) tick();
    idle(4 * CPB);
    check("fe_pulses", fe_cycles, 1);
    check("fe_valid", vld_cycles, 0);
    check("fe_ov", ov_cycles, 0);
    check("fe_keep_data", data, 8'h55);

    // Reset in the middle of the data bits of 0x81.
    clear_mon();
    rxd = 1'b0;
    repeat (CPB) tick();
    rxd = 1'b1;
    repeat (CPB) tick();
    rxd = 1'b0;
    repeat (HALF) tick();
    nReset = 1'b0;
    rxd = 1'b1;
    #2;
    check("midrst_data", data, 8'h00);
    check("midrst_flags", {valid, frame_err, overrun, parity_err}, 4'b0000);
    repeat (3) tick();
    nReset = 1'b1;
    idle(2 * CPB);
    check("post_rst_valid", vld_cycles, 0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1, 1'b0);
    idle(2 * CPB);
    check_queue("post_rst_7e");
    check("post_rst_data", data, 8'h7E);

`ifdef UART_RX_PARITY_EN
    // 0x01 needs parity 1 for even parity; send 0 first.
    clear_mon();
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1, 1'b1);
    idle(2 * CPB);
    check_queue("par_bad");
    check("par_bad_pulses", pe_cycles, 1);
    check("par_bad_same_cycle", pe_cyc, first_vld);
    clear_mon();
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1, 1'b0);
    idle(2 * CPB);
    check_queue("par_ok");
    check("par_ok_pulses", pe_cycles, 0);
`else
    check("parity_tied", pe_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
